// File: rtl/sprite_animator.sv
// Per-frame sprite motion and animation controller: once per video frame, in
// vertical blanking, moves the sprite on both axes and steps the animation frame.
module sprite_animator #(
  parameter int CORDW           = 12,
  parameter int H_RES           = 1920,
  parameter int V_RES           = 1080,
  parameter int H_RES_FULL      = 2200,
  parameter int V_RES_FULL      = 1125,
  parameter int SPR_W_PX        = 384,
  parameter int SPR_H_PX        = 240,
  parameter int FRAMES          = 4,
  parameter int FRAME_PIXELS    = 640,
  parameter int ADDRW           = 12,
  parameter int TICKS_PER_FRAME = 16,
  parameter int ANIM_MODE       = 0,
  parameter int MOVE_MODE       = 0,
  parameter int SPDW            = 4,
  parameter int X0              = 0,
  parameter int Y0              = 420,
  parameter int DIR_X0          = 1,
  parameter int DIR_Y0          = 0
) (
  input  logic                                          clk_pix,
  input  logic                                          rst_n,
  input  logic [CORDW-1:0]                              sx,
  input  logic [CORDW-1:0]                              sy,
  input  logic                                          en,
  input  logic                                          step,
  input  logic [SPDW-1:0]                               spd_x,
  input  logic [SPDW-1:0]                               spd_y,
  output logic [CORDW-1:0]                              sprx,
  output logic [CORDW-1:0]                              spry,
  output logic [ADDRW-1:0]                              spr_base_addr,
  output logic [(FRAMES > 1 ? $clog2(FRAMES) : 1)-1:0]  frame_idx,
  output logic                                          flip_x,
  output logic                                          spr_start,
  output logic                                          frame_tick,
  output logic                                          running
);

  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [FW-1:0]    LAST_IDX = FW'(FRAMES - 1);
  localparam logic [TW-1:0]    LAST_CNT = TW'(TICKS_PER_FRAME - 1);
  localparam logic [CORDW:0]   FULL_X   = (CORDW+1)'(H_RES_FULL);
  localparam logic [CORDW:0]   FULL_Y   = (CORDW+1)'(V_RES_FULL);
  localparam logic [CORDW:0]   LIM_X    = (CORDW+1)'(H_RES - SPR_W_PX);
  localparam logic [CORDW:0]   LIM_Y    = (CORDW+1)'(V_RES - SPR_H_PX);

  typedef enum logic [1:0] {PAUSE, ARMED, RUN} state_t;

  state_t         state, state_n;
  logic           dir_x, dir_y, pdir, pdir_n, do_upd;
  logic [TW-1:0]  cnt_tick, cnt_n;
  logic [FW-1:0]  idx_n;
  logic [CORDW:0] mx, my;

  // Returns {next direction, next position}; sums kept one bit wider than a coordinate.
  function automatic logic [CORDW:0] move(input logic [CORDW-1:0] pos, input logic [SPDW-1:0] spd,
                                          input logic dir, input logic [CORDW:0] full,
                                          input logic [CORDW:0] lim);
    logic [CORDW:0] p, s, sum, r;
    logic           d;
    p   = {1'b0, pos};
    s   = (CORDW+1)'(spd);
    sum = p + s;
    r   = p;
    d   = dir;
    if (spd != '0) begin
      if (MOVE_MODE == 0) begin
        if (dir) r = (p > s) ? p - s : full - (s - p);
        else     r = (sum >= full) ? sum - full : sum;
      end else if (dir) begin
        if (p <= s) begin r = '0; d = 1'b0; end
        else r = p - s;
      end else begin
        if (sum >= lim) begin r = lim; d = 1'b1; end
        else r = sum;
      end
    end
    return {d, r[CORDW-1:0]};
  endfunction

  assign mx = move(sprx, spd_x, dir_x, FULL_X, LIM_X);
  assign my = move(spry, spd_y, dir_y, FULL_Y, LIM_Y);

  always_comb begin
    cnt_n  = cnt_tick + 1'b1;
    idx_n  = frame_idx;
    pdir_n = pdir;
    if (cnt_tick == LAST_CNT) begin
      cnt_n = '0;
      if (FRAMES > 1) begin
        if (ANIM_MODE == 0) begin
          idx_n = (frame_idx == LAST_IDX) ? '0 : frame_idx + 1'b1;
        end else if (!pdir) begin
          if (frame_idx == LAST_IDX) begin idx_n = frame_idx - 1'b1; pdir_n = 1'b1; end
          else idx_n = frame_idx + 1'b1;
        end else begin
          if (frame_idx == '0) begin idx_n = frame_idx + 1'b1; pdir_n = 1'b0; end
          else idx_n = frame_idx - 1'b1;
        end
      end
    end
  end

  // A step arms immediately, even on a tick cycle, unless en already forces an update.
  always_comb begin
    do_upd  = 1'b0;
    state_n = state;
    if (state == PAUSE && step && !(frame_tick && en)) begin
      state_n = ARMED;
    end else if (frame_tick) begin
      if (en) begin
        do_upd  = 1'b1;
        state_n = RUN;
      end else begin
        do_upd  = (state == ARMED);
        state_n = PAUSE;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sprx          <= CORDW'(X0);
      spry          <= CORDW'(Y0);
      dir_x         <= (DIR_X0 != 0);
      dir_y         <= (DIR_Y0 != 0);
      flip_x        <= (DIR_X0 == 0);
      pdir          <= 1'b0;
      cnt_tick      <= '0;
      frame_idx     <= '0;
      spr_base_addr <= '0;
      frame_tick    <= 1'b0;
      state         <= PAUSE;
      running       <= 1'b0;
    end else begin
      frame_tick <= (sy == CORDW'(V_RES)) && (sx == '0);
      state      <= state_n;
      running    <= (state_n == RUN);
      if (do_upd) begin
        {dir_x, sprx} <= mx;
        {dir_y, spry} <= my;
        flip_x        <= !mx[CORDW];
        cnt_tick      <= cnt_n;
        pdir          <= pdir_n;
        frame_idx     <= idx_n;
        spr_base_addr <= ADDRW'(32'(idx_n) * FRAME_PIXELS);
      end
    end
  end

  assign spr_start = (sy == ((spry == '0) ? CORDW'(V_RES_FULL - 1) : spry - 1'b1)) &&
                     (sx == CORDW'(H_RES));

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Per-frame sprite motion and animation controller for the hardware-sprite display pipeline. Once per video frame, during vertical blanking, it advances the sprite position on both axes, in either wrap or bounce mode, with runtime speeds. It also steps a configurable animation sequence (loop or ping-pong) and supports pause and single-step control. Outputs feed the sprite ROM base address, the `sprite` engine's `sprx` and `start` inputs, and the CLUT/flip logic downstream.

## Interface

- Reset: one clock; reset is asynchronous and active-low.

Parameters:
- `CORDW`, 12, screen coordinate width in bits
- `H_RES`, 1920, active width
- `V_RES`, 1080, active height
- `H_RES_FULL`, 2200, total width including blanking
- `V_RES_FULL`, 1125, total height including blanking
- `SPR_W_PX`, 384, on-screen sprite width (width × scale)
- `SPR_H_PX`, 240, on-screen sprite height (height × scale)
- `FRAMES`, 4, animation frames in ROM (≥1)
- `FRAME_PIXELS`, 640, ROM words per frame
- `ADDRW`, 12, ROM address width
- `TICKS_PER_FRAME`, 16, video frames per animation step (≥1)
- `ANIM_MODE`, 0, animation order: 0 = loop, 1 = ping-pong
- `MOVE_MODE`, 0, edge handling: 0 = wrap, 1 = bounce
- `SPDW`, 4, speed input width
- `X0`, 0, reset x position
- `Y0`, 420, reset y position
- `DIR_X0`, 1, reset x direction (1 = decreasing)
- `DIR_Y0`, 0, reset y direction (1 = decreasing)

Ports:
- `clk_pix`, in, 1, pixel clock
- `rst_n`, in, 1, asynchronous active-low reset
- `sx`, `sy`, in, CORDW, current screen position
- `en`, in, 1, run animation and motion
- `step`, in, 1, single-cycle pulse: one update while paused
- `spd_x`, `spd_y`, in, SPDW, pixels moved per update
- `sprx`, `spry`, out, CORDW, sprite position
- `spr_base_addr`, out, ADDRW, ROM base address of the current frame
- `frame_idx`, out, $clog2(FRAMES) (min 1), current animation frame
- `flip_x`, out, 1, high when moving right (x increasing)
- `spr_start`, out, 1, start pulse to the sprite engine
- `frame_tick`, out, 1, one-cycle pulse per video frame
- `running`, out, 1, high when the controller is in state RUN

## Operation

- Tick: `frame_tick` is registered and asserts the cycle after `sy==V_RES && sx==0`. All updates happen on that cycle only, which keeps them inside blanking with no tearing.
- States: PAUSE (reset state), ARMED, RUN. The state is evaluated only when `frame_tick` is high:
  - `en` high: perform update; go to RUN.
  - `en` low, state ARMED: perform update; go to PAUSE.
  - Otherwise: go to PAUSE.
- Step:
  - `step` in PAUSE arms: next state ARMED, taking effect immediately, including on a `frame_tick` cycle. The update then happens at the following tick.
  - `step` is ignored in RUN and ARMED.
- Animation update:
  - `cnt_tick` increments. At `TICKS_PER_FRAME-1` it wraps to 0 and `frame_idx` advances.
  - Loop order: 0..FRAMES-1, 0, …
  - Ping-pong order: 0..FRAMES-1..1, 0, …, with an internal direction bit.
  - `FRAMES==1`: index stays 0.
  - `spr_base_addr` is registered and equals `frame_idx*FRAME_PIXELS`. It is updated in the same cycle as `frame_idx`.
- Motion update per axis, described for x; y is identical using V_RES, V_RES_FULL and SPR_H_PX:
  - Speed 0: position and direction held, in both modes.
  - Wrap, decreasing: if `sprx > spd`, `sprx - spd`; else `H_RES_FULL - (spd - sprx)`.
  - Wrap, increasing: if `sprx + spd >= H_RES_FULL`, `sprx + spd - H_RES_FULL`; else `sprx + spd`.
  - Bounce, with LIM = H_RES - SPR_W_PX:
    - Decreasing: if `sprx <= spd`, sprx = 0 and direction flips; else `sprx - spd`.
    - Increasing: if `sprx + spd >= LIM`, sprx = LIM and direction flips; else `sprx + spd`.
  - All sums are computed in CORDW+1 bits; there is no truncation before comparison.
- `flip_x` = !dir_x, registered; it changes on the same tick as a bounce.
- `spr_start` is combinational: `sy == (spry==0 ? V_RES_FULL-1 : spry-1) && sx == H_RES`.

## Timing

- Reset values (asynchronous):
  - sprx = X0, spry = Y0, dir_x = DIR_X0, dir_y = DIR_Y0, flip_x = !DIR_X0
  - frame_idx = 0, spr_base_addr = 0, cnt_tick = 0
  - frame_tick = 0, state = PAUSE, running = 0
- Latency: outputs change on the `frame_tick` cycle, i.e. 2 cycles after (sx=0, sy=V_RES).
- At most one update per video frame. `en` and `step` are sampled only as described above.
- Reset asserted mid-frame returns all state immediately. The first update after release requires `en` or `step` and a tick.

## Test plan

- Reset with `en`=0, then run 3 frames: sprx=0, spry=420, frame_idx=0, running=0, and no motion occurs.
- Wrap x, decreasing, spd_x=6, sprx=0, `en`=1: after one tick sprx=2194; after the next, 2188.
- Bounce, increasing, spd_x=10, sprx=1530 (LIM=1536): next tick sprx=1536, flip_x goes 1→0, dir decreasing; following tick sprx=1526.
- Ping-pong, FRAMES=4, TICKS_PER_FRAME=2, `en`=1 for 16 ticks: frame_idx sequence 0,0,1,1,2,2,3,3,2,2,1,1,0,0,1,1; base address tracks idx×640.
- Paused, one `step` pulse mid-frame: exactly one update at the next tick; none after. A `step` on a `frame_tick` cycle updates at the subsequent tick.
- spry=0: spr_start asserts at (sx=1920, sy=1124) only. spd=0 in bounce mode at sprx=0: no flip, no motion.
